// File: rtl/divider_pkg.sv
// Shared widths and FSM state encoding for the sequential divider and its multiplier counterpart.
package divider_pkg;
    localparam int DW = 8;
    localparam int VW = 4;

    // The divider is the inverse of the VW x VW multiplier, so its product width is DW.
    localparam int MUL_OP_W   = VW;
    localparam int MUL_PROD_W = 2 * MUL_OP_W;

    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;
endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift one dividend bit into the partial remainder and trial-subtract.
module div_step
    import divider_pkg::*;
(
    input  logic [VW:0]   r_in,
    input  logic          bit_in,
    input  logic [VW-1:0] divisor,
    output logic [VW:0]   r_out,
    output logic          q_bit
);

    logic [VW+1:0] wide;

    always_comb begin
        wide  = {r_in, bit_in};
        q_bit = (wide >= (VW+2)'(divisor));
        r_out = (VW+1)'(q_bit ? wide - (VW+2)'(divisor) : wide);
    end

endmodule

// File: rtl/seq_divider_8by4.sv
// Sequential restoring divider, DW-bit dividend by VW-bit divisor, one quotient bit per clock.
module seq_divider_8by4
    import divider_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          div_by_zero
);

    state_t        state, state_nx;
    logic [VW:0]   rem_p;
    logic [DW-1:0] quo_p;
    logic [CW-1:0] cnt;
    logic [VW-1:0] dvs;
    logic [VW:0]   rem_nx;
    logic          q_bit;
    logic          accept;
    logic          last;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(1));

    div_step u_step (
        .r_in    (rem_p),
        .bit_in  (quo_p[DW-1]),
        .divisor (dvs),
        .r_out   (rem_nx),
        .q_bit   (q_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE, DONE: begin
                done     = (state == DONE);
                // A zero divisor skips RUN and reports straight away.
                state_nx = start ? ((divisor == '0) ? DONE : RUN) : IDLE;
            end
            RUN: begin
                busy = 1'b1;
                if (last) begin
                    state_nx = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Results stay put after done until the next operation completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_p       <= '0;
            quo_p       <= '0;
            cnt         <= '0;
            dvs         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            rem_p <= '0;
            quo_p <= dividend;
            cnt   <= CW'(DW);
            dvs   <= divisor;
            if (divisor == '0) begin
                quotient    <= '1;
                remainder   <= dividend[VW-1:0];
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            rem_p <= rem_nx;
            quo_p <= {quo_p[DW-2:0], q_bit};
            cnt   <= cnt - CW'(1);
            if (last) begin
                quotient    <= {quo_p[DW-2:0], q_bit};
                remainder   <= rem_nx[VW-1:0];
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_divider_8by4.sv
// Scoreboard bench for seq_divider_8by4: directed divisions with hand-computed results.
module tb_seq_divider_8by4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [3:0] divisor;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;

    typedef struct packed {
        logic [7:0] q;
        logic [3:0] r;
        logic       z;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    seq_divider_8by4 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: q=%0d r=%0d z=%0d with nothing outstanding",
                         quotient, remainder, div_by_zero);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if ({quotient, remainder, div_by_zero} !== {e.q, e.r, e.z}) begin
                    fails++;
                    $display("FAIL result: got q=%0d r=%0d z=%0d, expected q=%0d r=%0d z=%0d",
                             quotient, remainder, div_by_zero, e.q, e.r, e.z);
                end
            end
        end
    end

    // Drive one start for one edge and record the expected result.
    task automatic issue(input logic [7:0] a, input logic [3:0] b,
                         input logic [7:0] eq, input logic [3:0] er, input logic ez);
        exp_t e;
        e.q = eq; e.r = er; e.z = ez;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        sb.push_back(e);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Count edges from the accept edge until done; also counts busy cycles seen.
    task automatic wait_done(input string name, input int exp_edges, input int exp_busy);
        int n = 0;
        int busy_cycles = 0;
        while (!done && n < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            n++;
        end
        check({name, "_latency"}, n, exp_edges);
        if (exp_busy >= 0) check({name, "_busy_cycles"}, busy_cycles, exp_busy);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        @(posedge clk); @(posedge clk); #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_outputs", {quotient, remainder, div_by_zero}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
        wait_done("div225_15", 8, 8);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);

        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        wait_done("div200_7", 8, 8);
        issue(8'd18, 4'd2, 8'd9, 4'd0, 1'b0);
        check("b2b_no_gap_busy", busy, 1);
        wait_done("div18_2", 8, 8);
        @(posedge clk); #1;

        issue(8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
        wait_done("div255_1", 8, -1);
        @(posedge clk); #1;
        issue(8'd3, 4'd15, 8'd0, 4'd3, 1'b0);
        wait_done("div3_15", 8, -1);
        @(posedge clk); #1;

        issue(8'd42, 4'd0, 8'hFF, 4'hA, 1'b1);
        check("dbz_busy_low", busy, 0);
        wait_done("div42_0", 0, 0);
        @(posedge clk); #1;

        // Start during RUN must be ignored.
        issue(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        dividend = 8'd100;
        divisor  = 4'd9;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done("ignored_start", 5, -1);
        repeat (6) begin @(posedge clk); #1; end
        check("hold_quotient", quotient, 15);
        check("hold_remainder", remainder, 0);
        check("hold_idle_busy", busy, 0);

        // Asynchronous reset mid-division.
        issue(8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        check("async_rst_quotient", quotient, 0);
        check("async_rst_rem_dbz", {remainder, div_by_zero}, 0);
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        issue(8'd24, 4'd4, 8'd6, 4'd0, 1'b0);
        wait_done("div24_4", 8, 8);
        repeat (3) begin @(posedge clk); #1; end

        check("scoreboard_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
